// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    DRAIN,
    HOLD,
    HALT
  } fetch_state_e;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues single-word bus reads, holds one word for decode.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned redirect targets into fault words.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        I_clk,
  input  logic        I_reset,
  output logic        O_bus_req,
  output logic [31:0] O_bus_addr,
  input  logic        I_bus_ack,
  input  logic [31:0] I_bus_data,
  input  logic        I_bus_err,
  input  logic        I_redirect,
  input  logic [31:0] I_redirect_pc,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_fault
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  pend_pc, pend_n;
  logic [31:0]  instr_n, opc_n;
  logic         fault_n;
  logic         take;
  logic [31:0]  tgt;

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
      O_instr <= NOP;
      O_pc    <= RESET_PC;
      O_fault <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
      O_instr <= instr_n;
      O_pc    <= opc_n;
      O_fault <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    pend_n  = pend_pc;
    instr_n = O_instr;
    opc_n   = O_pc;
    fault_n = O_fault;
    take    = 1'b0;
    tgt     = I_redirect_pc;
    case (state)
      BOOT: begin
        state_n = REQ;
        take    = I_redirect;
      end
      REQ: begin
        if (I_redirect) begin
          if (I_bus_ack) take = 1'b1;
          else begin
            // Bus must not be withdrawn: park the target until the ack arrives.
            pend_n  = I_redirect_pc;
            state_n = DRAIN;
          end
        end else if (I_bus_ack) begin
          instr_n = I_bus_err ? NOP : I_bus_data;
          opc_n   = pc;
          fault_n = I_bus_err;
          state_n = HOLD;
        end
      end
      DRAIN: begin
        if (I_bus_ack) begin
          take = 1'b1;
          tgt  = I_redirect ? I_redirect_pc : pend_pc;
        end else if (I_redirect) begin
          pend_n = I_redirect_pc;
        end
      end
      HOLD: begin
        if (I_redirect) take = 1'b1;
        else if (I_ready) begin
          pc_n    = O_pc + 32'd4;
          state_n = O_fault ? HALT : REQ;
        end
      end
      HALT: take = I_redirect;
      default: state_n = BOOT;
    endcase

    if (take) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) begin
        instr_n = NOP;
        opc_n   = tgt;
        fault_n = 1'b1;
        state_n = HOLD;
      end else begin
        pc_n    = tgt;
        state_n = REQ;
      end
`else
      pc_n    = word_align(tgt);
      state_n = REQ;
`endif
    end
  end

  assign O_bus_req  = (state == REQ) || (state == DRAIN);
  assign O_bus_addr = word_align(pc);
  assign O_valid    = (state == HOLD);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector table plus randomized bus/decode/redirect traffic checked against a word-stream model.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        I_clk = 1'b0;
  logic        I_reset = 1'b1;
  logic        O_bus_req;
  logic [31:0] O_bus_addr;
  logic        I_bus_ack = 1'b0;
  logic [31:0] I_bus_data = '0;
  logic        I_bus_err = 1'b0;
  logic        I_redirect = 1'b0;
  logic [31:0] I_redirect_pc = '0;
  logic        O_valid;
  logic        I_ready = 1'b0;
  logic [31:0] O_instr;
  logic [31:0] O_pc;
  logic        O_fault;

  instr_fetch dut (
    .I_clk(I_clk), .I_reset(I_reset),
    .O_bus_req(O_bus_req), .O_bus_addr(O_bus_addr),
    .I_bus_ack(I_bus_ack), .I_bus_data(I_bus_data), .I_bus_err(I_bus_err),
    .I_redirect(I_redirect), .I_redirect_pc(I_redirect_pc),
    .O_valid(O_valid), .I_ready(I_ready),
    .O_instr(O_instr), .O_pc(O_pc), .O_fault(O_fault)
  );

  always #5 I_clk = ~I_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        ack, err, redir, ready;
    logic [31:0] data, rpc;
    logic        req, valid, fault;
    logic [31:0] addr, instr, pc;
  } vec_t;

  function automatic vec_t mk(input logic ack, input logic err, input logic redir, input logic ready,
                              input logic [31:0] data, input logic [31:0] rpc,
                              input logic req, input logic valid, input logic fault,
                              input logic [31:0] addr, input logic [31:0] instr, input logic [31:0] pc);
    vec_t v;
    v.ack = ack; v.err = err; v.redir = redir; v.ready = ready; v.data = data; v.rpc = rpc;
    v.req = req; v.valid = valid; v.fault = fault; v.addr = addr; v.instr = instr; v.pc = pc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[6:2] == 5'd7;
  endfunction

  task automatic chk_reset();
    chk("rst_req", O_bus_req, 0);
    chk("rst_addr", O_bus_addr, 32'h0);
    chk("rst_valid", O_valid, 0);
    chk("rst_fault", O_fault, 0);
    chk("rst_instr", O_instr, NOP);
    chk("rst_pc", O_pc, 32'h0);
  endtask

  localparam int NV = 29;
  vec_t vecs[NV];

  // random-phase model state
  logic [31:0] m_pc, txn_addr, t, exp_i;
  logic        halted, forced, txn_open, ack, rdy, r, exp_f;
  int          idle, accepts;

  initial begin
    //          ack err rdr rdy data          rpc            req val flt addr          instr         pc
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,        32'h0,          1, 0, 0, 32'h0,        32'h0,        32'h0);
    vecs[1]  = mk(1, 0, 0, 0, 32'h00500093, 32'h0,          0, 1, 0, 32'h0,        32'h00500093, 32'h0);
    vecs[2]  = mk(0, 0, 0, 1, 32'h0,        32'h0,          1, 0, 0, 32'h4,        32'h0,        32'h0);
    vecs[3]  = mk(1, 0, 0, 0, 32'hAAAA0001, 32'h0,          0, 1, 0, 32'h0,        32'hAAAA0001, 32'h4);
    for (int i = 4; i < 9; i++)
      vecs[i] = mk(0, 0, 0, 0, 32'h0,       32'h0,          0, 1, 0, 32'h0,        32'hAAAA0001, 32'h4);
    vecs[9]  = mk(0, 0, 0, 1, 32'h0,        32'h0,          1, 0, 0, 32'h8,        32'h0,        32'h0);
    vecs[10] = mk(0, 0, 1, 0, 32'h0,        32'h100,        1, 0, 0, 32'h8,        32'h0,        32'h0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,        32'h0,          1, 0, 0, 32'h8,        32'h0,        32'h0);
    vecs[12] = mk(0, 0, 0, 1, 32'h0,        32'h0,          1, 0, 0, 32'h8,        32'h0,        32'h0);
    vecs[13] = mk(1, 0, 0, 0, 32'hDEADBEEF, 32'h0,          1, 0, 0, 32'h100,      32'h0,        32'h0);
    vecs[14] = mk(1, 0, 0, 0, 32'h11111111, 32'h0,          0, 1, 0, 32'h0,        32'h11111111, 32'h100);
    vecs[15] = mk(0, 0, 1, 1, 32'h0,        32'h1C,         1, 0, 0, 32'h1C,       32'h0,        32'h0);
    vecs[16] = mk(1, 0, 0, 0, 32'h22222222, 32'h0,          0, 1, 0, 32'h0,        32'h22222222, 32'h1C);
    vecs[17] = mk(0, 0, 0, 1, 32'h0,        32'h0,          1, 0, 0, 32'h20,       32'h0,        32'h0);
    vecs[18] = mk(1, 1, 0, 0, 32'h33333333, 32'h0,          0, 1, 1, 32'h0,        NOP,          32'h20);
    vecs[19] = mk(0, 0, 0, 1, 32'h0,        32'h0,          0, 0, 0, 32'h0,        32'h0,        32'h0);
    vecs[20] = mk(0, 0, 0, 1, 32'h0,        32'h0,          0, 0, 0, 32'h0,        32'h0,        32'h0);
    vecs[21] = mk(0, 0, 1, 0, 32'h0,        32'h40,         1, 0, 0, 32'h40,       32'h0,        32'h0);
    vecs[22] = mk(1, 0, 0, 0, 32'h44,       32'h0,          0, 1, 0, 32'h0,        32'h44,       32'h40);
    vecs[23] = mk(0, 0, 1, 0, 32'h0,        32'hFFFFFFFC,   1, 0, 0, 32'hFFFFFFFC, 32'h0,        32'h0);
    vecs[24] = mk(1, 0, 0, 0, 32'h55,       32'h0,          0, 1, 0, 32'h0,        32'h55,       32'hFFFFFFFC);
    vecs[25] = mk(0, 0, 0, 1, 32'h0,        32'h0,          1, 0, 0, 32'h0,        32'h0,        32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    vecs[26] = mk(1, 0, 1, 0, 32'h66,       32'h102,        0, 1, 1, 32'h0,        NOP,          32'h102);
    vecs[27] = mk(1, 0, 0, 0, 32'h77,       32'h0,          0, 1, 1, 32'h0,        NOP,          32'h102);
    vecs[28] = mk(0, 0, 0, 1, 32'h0,        32'h0,          0, 0, 0, 32'h0,        32'h0,        32'h0);
`else
    vecs[26] = mk(1, 0, 1, 0, 32'h66,       32'h102,        1, 0, 0, 32'h100,      32'h0,        32'h0);
    vecs[27] = mk(1, 0, 0, 0, 32'h77,       32'h0,          0, 1, 0, 32'h0,        32'h77,       32'h100);
    vecs[28] = mk(0, 0, 0, 1, 32'h0,        32'h0,          1, 0, 0, 32'h104,      32'h0,        32'h0);
`endif

    // ---- directed table ----
    repeat (2) @(negedge I_clk);
    chk_reset();
    I_reset = 1'b0;
    for (int i = 0; i < NV; i++) begin
      I_bus_ack = vecs[i].ack; I_bus_err = vecs[i].err; I_bus_data = vecs[i].data;
      I_redirect = vecs[i].redir; I_redirect_pc = vecs[i].rpc; I_ready = vecs[i].ready;
      @(negedge I_clk);
      chk($sformatf("v%0d_req", i), O_bus_req, vecs[i].req);
      chk($sformatf("v%0d_valid", i), O_valid, vecs[i].valid);
      if (vecs[i].req) chk($sformatf("v%0d_addr", i), O_bus_addr, vecs[i].addr);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_instr", i), O_instr, vecs[i].instr);
        chk($sformatf("v%0d_pc", i), O_pc, vecs[i].pc);
        chk($sformatf("v%0d_fault", i), O_fault, vecs[i].fault);
      end
    end

    // ---- reset mid-stream, then randomized traffic ----
    I_bus_ack = 0; I_bus_err = 0; I_redirect = 0; I_ready = 0;
    I_reset = 1'b1;
    repeat (2) @(negedge I_clk);
    chk_reset();
    I_reset = 1'b0;
    m_pc = 32'h0; halted = 0; forced = 0; txn_open = 0; txn_addr = 0; idle = 0; accepts = 0;

    repeat (4000) begin
      @(negedge I_clk);
      if (halted) begin
        chk("halt_req", O_bus_req, 0);
        chk("halt_valid", O_valid, 0);
      end
      if (O_bus_req) begin
        if (!txn_open) begin
          chk("req_addr", O_bus_addr, m_pc);
          txn_open = 1; txn_addr = O_bus_addr;
        end else chk("req_hold", O_bus_addr, txn_addr);
      end
      if (O_valid) begin
        exp_f = forced || mem_err(m_pc);
        exp_i = exp_f ? NOP : mem_word(m_pc);
        chk("word_pc", O_pc, m_pc);
        chk("word_fault", O_fault, exp_f);
        chk("word_instr", O_instr, exp_i);
      end
      if (!halted && !O_bus_req && !O_valid) idle++; else idle = 0;
      if (idle > 2) begin
        chk("stall_cycles", idle, 0);
        idle = 0;
      end

      ack  = O_bus_req && ($urandom_range(2) == 0);
      rdy  = ($urandom_range(1) == 1);
      r    = ($urandom_range(19) == 0) || (halted && $urandom_range(3) == 0);
      case ($urandom_range(7))
        0:       t = 32'hFFFF_FFF0 + 32'($urandom_range(3)) * 4;
        1:       t = (32'($urandom_range(1023)) << 2) | 32'($urandom_range(3, 1));
        default: t = 32'($urandom_range(1023)) << 2;
      endcase
      I_bus_ack = ack;
      I_bus_data = ack ? mem_word(O_bus_addr) : $urandom;
      I_bus_err = ack ? mem_err(O_bus_addr) : 1'($urandom_range(1));
      I_ready = rdy; I_redirect = r; I_redirect_pc = t;

      if (r) begin
`ifdef FETCH_MISALIGN_CHECK_EN
        forced = (t[1:0] != 2'b00);
        m_pc = t;
`else
        forced = 0;
        m_pc = {t[31:2], 2'b00};
`endif
        halted = 0;
      end else if (O_valid && rdy) begin
        if (forced || mem_err(m_pc)) halted = 1;
        else m_pc = m_pc + 32'd4;
        forced = 0;
        accepts++;
      end
      if (ack) txn_open = 0;
    end
    chk("progress", 32'(accepts > 50), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
